// File: rtl/pid_pwm_sched.sv
// Control-loop scheduler: ticks the loop, runs PID0 then PID1 with a start/done
// handshake, then commits saturated H-bridge duties once per period with a reversal dead time.
module pid_pwm_sched #(
    parameter int SHIFT    = 15,
    parameter int DUTY_MAX = 9999,
    parameter int DUTY_MIN = 1,
    parameter int DEADTIME = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic [31:0] CTL_PERIOD,
    input  logic [31:0] QEI_CNT,
    output logic [31:0] CUR_SNAP,
    output logic        PID0_START,
    output logic        PID1_START,
    input  logic        PID0_DONE,
    input  logic        PID1_DONE,
    input  logic [31:0] PID0_OUT,
    input  logic [31:0] PID1_OUT,
    output logic [31:0] CH0_DUTY,
    output logic [31:0] CH1_DUTY,
    output logic        DUTY_UPD,
    output logic        DIR,
    output logic        BUSY,
    output logic        FAULT,
    input  logic        FAULT_CLR,
    output logic [15:0] OVERRUN_CNT
);

    localparam int          TMR_MAX  = (TIMEOUT > DEADTIME) ? TIMEOUT : DEADTIME;
    localparam int          TW       = $clog2(TMR_MAX + 1);
    localparam logic [31:0] DMIN     = 32'(DUTY_MIN);
    localparam logic [31:0] DMAX     = 32'(DUTY_MAX);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(DEADTIME - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_SNAP, S_RUN0, S_RUN1, S_CALC, S_DEAD, S_COMMIT, S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [31:0]   pid0_q, pid0_d, pid1_q, pid1_d;
    logic [31:0]   snap_q, snap_d;
    logic [31:0]   ch0_q, ch0_d, ch1_q, ch1_d;
    logic          dir_q, dir_d, upd_q, upd_d;
    logic          start0_q, start0_d, start1_q, start1_d;
    logic          busy_q, busy_d, fault_q, fault_d;
    logic [15:0]   ovr_q, ovr_d;

    logic          running, tick;
    logic [31:0]   reload;
    logic signed [32:0] diff;
    logic [32:0]   mag, shifted;
    logic [31:0]   calc_duty, calc_ch0, calc_ch1, active_duty;
    logic          calc_dir;

    // 33-bit difference so opposite-sign extremes cannot wrap.
    always_comb begin
        diff     = $signed({pid0_q[31], pid0_q}) - $signed({pid1_q[31], pid1_q});
        calc_dir = diff[32];
        mag      = calc_dir ? -diff : diff;
        shifted  = mag >> SHIFT;
        if (shifted > 33'(DUTY_MAX))      calc_duty = DMAX;
        else if (shifted < 33'(DUTY_MIN)) calc_duty = DMIN;
        else                              calc_duty = shifted[31:0];
        calc_ch0    = calc_dir ? DMIN : calc_duty;
        calc_ch1    = calc_dir ? calc_duty : DMIN;
        active_duty = dir_q ? ch1_q : ch0_q;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        pid0_d   = pid0_q;
        pid1_d   = pid1_q;
        snap_d   = snap_q;
        ch0_d    = ch0_q;
        ch1_d    = ch1_q;
        dir_d    = dir_q;
        ovr_d    = ovr_q;
        start0_d = 1'b0;
        start1_d = 1'b0;

        reload  = (CTL_PERIOD < 32'd2) ? 32'd1 : CTL_PERIOD - 32'd1;
        running = ENABLE && (state_q != S_IDLE) && (state_q != S_FAULT);
        tick    = running && (cnt_q == 32'd0);
        if (running) cnt_d = tick ? reload : cnt_q - 32'd1;
        if (tick && state_q != S_WAIT && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;

        case (state_q)
            S_IDLE: if (ENABLE) begin
                state_d = S_WAIT;
                cnt_d   = reload;
            end
            S_WAIT: if (tick) state_d = S_SNAP;
            S_SNAP: begin
                snap_d   = QEI_CNT;
                state_d  = S_RUN0;
                start0_d = 1'b1;
                tmr_d    = '0;
            end
            S_RUN0: begin
                // DONE on the timeout cycle still wins; the START cycle itself is ignored.
                if (!start0_q && PID0_DONE) begin
                    pid0_d   = PID0_OUT;
                    state_d  = S_RUN1;
                    start1_d = 1'b1;
                    tmr_d    = '0;
                end else if (tmr_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RUN1: begin
                if (!start1_q && PID1_DONE) begin
                    pid1_d  = PID1_OUT;
                    state_d = S_CALC;
                end else if (tmr_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_CALC: begin
                if (calc_dir != dir_q && active_duty > DMIN) begin
                    state_d = S_DEAD;
                    ch0_d   = DMIN;
                    ch1_d   = DMIN;
                    tmr_d   = '0;
                end else begin
                    state_d = S_COMMIT;
                    ch0_d   = calc_ch0;
                    ch1_d   = calc_ch1;
                    dir_d   = calc_dir;
                end
            end
            S_DEAD: begin
                if (tmr_q == DEAD_LAST) begin
                    state_d = S_COMMIT;
                    ch0_d   = calc_ch0;
                    ch1_d   = calc_ch1;
                    dir_d   = calc_dir;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_COMMIT: state_d = S_WAIT;
            S_FAULT:  if (FAULT_CLR) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_d == S_FAULT && state_q != S_FAULT) begin
            ch0_d = DMIN;
            ch1_d = DMIN;
            dir_d = 1'b0;
        end

        if (!ENABLE && state_q != S_FAULT) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ch0_d    = DMIN;
            ch1_d    = DMIN;
            dir_d    = 1'b0;
            start0_d = 1'b0;
            start1_d = 1'b0;
        end

        busy_d  = state_d inside {S_SNAP, S_RUN0, S_RUN1, S_CALC, S_DEAD, S_COMMIT};
        fault_d = (state_d == S_FAULT);
        upd_d   = (ch0_d != ch0_q) || (ch1_d != ch1_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            pid0_q   <= '0;
            pid1_q   <= '0;
            snap_q   <= '0;
            ch0_q    <= DMIN;
            ch1_q    <= DMIN;
            dir_q    <= 1'b0;
            upd_q    <= 1'b0;
            start0_q <= 1'b0;
            start1_q <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            pid0_q   <= pid0_d;
            pid1_q   <= pid1_d;
            snap_q   <= snap_d;
            ch0_q    <= ch0_d;
            ch1_q    <= ch1_d;
            dir_q    <= dir_d;
            upd_q    <= upd_d;
            start0_q <= start0_d;
            start1_q <= start1_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
            ovr_q    <= ovr_d;
        end
    end

    assign CUR_SNAP    = snap_q;
    assign PID0_START  = start0_q;
    assign PID1_START  = start1_q;
    assign CH0_DUTY    = ch0_q;
    assign CH1_DUTY    = ch1_q;
    assign DUTY_UPD    = upd_q;
    assign DIR         = dir_q;
    assign BUSY        = busy_q;
    assign FAULT       = fault_q;
    assign OVERRUN_CNT = ovr_q;

endmodule

// File: tb/tb_pid_pwm_sched.sv
// Directed bench for pid_pwm_sched: a vector table of PID results with hand-computed
// duties, plus hand-written sequences for dead time, timeout, overrun and reset.
module tb_pid_pwm_sched;

    logic        CLK = 1'b0;
    logic        RST, ENABLE, FAULT_CLR;
    logic [31:0] CTL_PERIOD, QEI_CNT, PID0_OUT, PID1_OUT;
    logic        PID0_DONE, PID1_DONE;
    logic [31:0] CUR_SNAP, CH0_DUTY, CH1_DUTY;
    logic        PID0_START, PID1_START, DUTY_UPD, DIR, BUSY, FAULT;
    logic [15:0] OVERRUN_CNT;

    always #5 CLK = ~CLK;

    pid_pwm_sched dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CTL_PERIOD(CTL_PERIOD),
        .QEI_CNT(QEI_CNT), .CUR_SNAP(CUR_SNAP),
        .PID0_START(PID0_START), .PID1_START(PID1_START),
        .PID0_DONE(PID0_DONE), .PID1_DONE(PID1_DONE),
        .PID0_OUT(PID0_OUT), .PID1_OUT(PID1_OUT),
        .CH0_DUTY(CH0_DUTY), .CH1_DUTY(CH1_DUTY), .DUTY_UPD(DUTY_UPD),
        .DIR(DIR), .BUSY(BUSY), .FAULT(FAULT), .FAULT_CLR(FAULT_CLR),
        .OVERRUN_CNT(OVERRUN_CNT)
    );

    typedef struct {
        logic [31:0] p0, p1, qei, ch0, ch1;
        logic        dir;
        int          upd;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0, n_err = 0;
    int cyc = 0, n_start0 = 0, n_start1 = 0, n_upd = 0;
    int last_s0 = 0, prev_s0 = 0, bad_start = 0;
    int dly0 = 3, dly1 = 3, cnt0 = 0, cnt1 = 0;   // dly = 0 withholds DONE
    bit pend1 = 0;
    logic done0_r = 1'b0, done1_r = 1'b0;

    assign PID0_DONE = done0_r;
    assign PID1_DONE = done1_r;

    // PID responders and event counters, evaluated 1 ns after each rising edge.
    initial forever begin
        @(posedge CLK);
        #1;
        cyc++;
        done0_r = 1'b0;
        done1_r = 1'b0;
        if (DUTY_UPD) n_upd++;
        if (RST || FAULT) pend1 = 0;
        if (PID0_START) begin
            n_start0++;
            prev_s0 = last_s0;
            last_s0 = cyc;
            if (pend1) bad_start++;
            cnt0 = dly0;
        end else if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) done0_r = 1'b1;
        end
        if (PID1_START) begin
            n_start1++;
            pend1 = 1;
            cnt1 = dly1;
        end else if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) begin
                done1_r = 1'b1;
                pend1 = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    task automatic wait_start(input bit which, input int limit, input string name);
        int base = which ? n_start1 : n_start0;
        int i = 0;
        while (((which ? n_start1 : n_start0) == base) && i < limit) begin
            @(negedge CLK);
            i++;
        end
        if ((which ? n_start1 : n_start0) == base) fail_bound(name);
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_ch0"},   CH0_DUTY, 32'd1);
        check({p, "_ch1"},   CH1_DUTY, 32'd1);
        check({p, "_dir"},   32'(DIR), 32'd0);
        check({p, "_upd"},   32'(DUTY_UPD), 32'd0);
        check({p, "_st0"},   32'(PID0_START), 32'd0);
        check({p, "_st1"},   32'(PID1_START), 32'd0);
        check({p, "_busy"},  32'(BUSY), 32'd0);
        check({p, "_fault"}, 32'(FAULT), 32'd0);
        check({p, "_snap"},  CUR_SNAP, 32'd0);
        check({p, "_ovr"},   32'(OVERRUN_CNT), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, i, upd_base, base, ovr_base;

        // p0, p1, qei, ch0, ch1, dir, DUTY_UPD pulses during that tick
        vecs[0] = '{32'd6553600,   32'd0,         32'h0000_1234, 32'd200,  32'd1,    1'b0, 1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_5678, 32'd9999, 32'd1,    1'b0, 1};
        vecs[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0001, 32'd1,    32'd9999, 1'b1, 2};
        vecs[3] = '{32'd0,         32'd0,         32'h0000_0042, 32'd1,    32'd1,    1'b0, 1};
        vecs[4] = '{32'd163840,    32'd0,         32'h0000_0099, 32'd5,    32'd1,    1'b0, 1};
        vecs[5] = '{32'd32767,     32'd0,         32'h0000_0100, 32'd1,    32'd1,    1'b0, 1};
        vecs[6] = '{32'd0,         32'd3276800,   32'h0000_0200, 32'd1,    32'd100,  1'b1, 1};
        vecs[7] = '{32'hFFFF_FFFF, 32'd0,         32'hDEAD_BEEF, 32'd1,    32'd1,    1'b1, 1};

        RST = 1'b1; ENABLE = 1'b1; FAULT_CLR = 1'b0;
        CTL_PERIOD = 32'd100; QEI_CNT = '0; PID0_OUT = '0; PID1_OUT = '0;
        repeat (3) @(negedge CLK);
        check_reset_state("reset");
        RST = 1'b0;

        for (int v = 0; v < 8; v++) begin
            PID0_OUT = vecs[v].p0;
            PID1_OUT = vecs[v].p1;
            QEI_CNT  = vecs[v].qei;
            upd_base = n_upd;
            wait_start(1'b1, 300, $sformatf("vec%0d_start1", v));
            repeat (30) @(negedge CLK);
            check($sformatf("vec%0d_ch0", v),  CH0_DUTY, vecs[v].ch0);
            check($sformatf("vec%0d_ch1", v),  CH1_DUTY, vecs[v].ch1);
            check($sformatf("vec%0d_dir", v),  32'(DIR), 32'(vecs[v].dir));
            check($sformatf("vec%0d_snap", v), CUR_SNAP, vecs[v].qei);
            check($sformatf("vec%0d_busy", v), 32'(BUSY), 32'd0);
            check($sformatf("vec%0d_upd", v),  32'(n_upd - upd_base), 32'(vecs[v].upd));
            if (v > 0) check($sformatf("vec%0d_spacing", v), 32'(last_s0 - prev_s0), 32'd100);
        end

        // Reversal from CH0=200: 16 cycles of 1/1, then CH1=100.
        PID0_OUT = 32'd6553600; PID1_OUT = 32'd0;
        wait_start(1'b1, 300, "pre_dead_start1");
        repeat (30) @(negedge CLK);
        check("pre_dead_ch0", CH0_DUTY, 32'd200);
        PID0_OUT = 32'd0; PID1_OUT = 32'd3276800;
        upd_base = n_upd;
        i = 0;
        while (!DUTY_UPD && i < 300) begin
            @(negedge CLK);
            i++;
        end
        if (!DUTY_UPD) fail_bound("dead_entry");
        check("dead_ch0", CH0_DUTY, 32'd1);
        check("dead_ch1", CH1_DUTY, 32'd1);
        check("dead_busy", 32'(BUSY), 32'd1);
        k = 0;
        while (CH0_DUTY == 32'd1 && CH1_DUTY == 32'd1 && k < 100) begin
            k++;
            @(negedge CLK);
        end
        check("dead_len", 32'(k), 32'd16);
        check("dead_commit_ch0", CH0_DUTY, 32'd1);
        check("dead_commit_ch1", CH1_DUTY, 32'd100);
        check("dead_commit_dir", 32'(DIR), 32'd1);
        check("dead_commit_upd", 32'(DUTY_UPD), 32'd1);
        repeat (10) @(negedge CLK);
        check("dead_upd_count", 32'(n_upd - upd_base), 32'd2);

        // PID1 never answers: FAULT 1024 cycles after PID1_START.
        dly1 = 0;
        wait_start(1'b1, 300, "to_start1");
        k = 0;
        while (!FAULT && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        check("timeout_cycles", 32'(k), 32'd1024);
        check("fault_ch0", CH0_DUTY, 32'd1);
        check("fault_ch1", CH1_DUTY, 32'd1);
        check("fault_dir", 32'(DIR), 32'd0);
        check("fault_busy", 32'(BUSY), 32'd0);
        base = n_start0;
        ENABLE = 1'b0;
        repeat (20) @(negedge CLK);
        ENABLE = 1'b1;
        repeat (280) @(negedge CLK);
        check("fault_no_start", 32'(n_start0 - base), 32'd0);
        check("fault_sticky", 32'(FAULT), 32'd1);

        // Clear edge -> IDLE, next edge -> WAIT_TICK loaded with 99, tick 99 edges
        // later, then SNAP and RUN0: START lands 102 edges after the clear edge.
        dly1 = 3;
        FAULT_CLR = 1'b1;
        @(negedge CLK);
        FAULT_CLR = 1'b0;
        check("fault_cleared", 32'(FAULT), 32'd0);
        k = 1;
        while (!PID0_START && k < 400) begin
            @(negedge CLK);
            k++;
        end
        check("resume_start_delay", 32'(k), 32'd103);
        wait_start(1'b1, 300, "resume_start1");
        repeat (30) @(negedge CLK);
        check("resume_ch1", CH1_DUTY, 32'd100);
        check("resume_dir", 32'(DIR), 32'd1);

        ENABLE = 1'b0;
        @(negedge CLK);
        check("dis_ch0", CH0_DUTY, 32'd1);
        check("dis_ch1", CH1_DUTY, 32'd1);
        check("dis_dir", 32'(DIR), 32'd0);
        check("dis_upd", 32'(DUTY_UPD), 32'd1);
        check("dis_busy", 32'(BUSY), 32'd0);
        ENABLE = 1'b1;

        // Period 10 with 20-cycle DONE latency: sequence spans 50 cycles, 4 ticks dropped.
        CTL_PERIOD = 32'd10; dly0 = 20; dly1 = 20;
        wait_start(1'b0, 400, "ovr_start_a");
        wait_start(1'b0, 400, "ovr_start_b");
        ovr_base = 32'(OVERRUN_CNT);
        wait_start(1'b0, 400, "ovr_start_c");
        check("ovr_delta", 32'(OVERRUN_CNT) - 32'(ovr_base), 32'd4);
        check("ovr_spacing", 32'(last_s0 - prev_s0), 32'd50);
        check("ovr_no_overlap", 32'(bad_start), 32'd0);

        // Reset inside RUN0; the responder's pending DONE then arrives as a stray.
        CTL_PERIOD = 32'd100; dly0 = 3; dly1 = 3;
        wait_start(1'b0, 400, "rst_start0");
        base = n_start1;
        RST = 1'b1;
        @(negedge CLK);
        check_reset_state("midrst");
        RST = 1'b0;
        k = 0;
        repeat (10) begin
            @(negedge CLK);
            k++;
        end
        check("stray_busy", 32'(BUSY), 32'd0);
        check("stray_no_start1", 32'(n_start1 - base), 32'd0);
        check("stray_ch0", CH0_DUTY, 32'd1);
        while (!PID0_START && k < 400) begin
            @(negedge CLK);
            k++;
        end
        check("post_rst_start_delay", 32'(k), 32'd102);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
